// File: rtl/word_serializer_pkg.sv
// Shared types and default widths for the word-to-byte serializer.
package word_serializer_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;

endpackage

// File: rtl/word_serializer.sv
// Splits one accepted word into BEATS byte-wide beats over a valid/ready stream.
// Optional macro WORD_SERIALIZER_LAST_EN adds a dataLast flag on the final beat of each word.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [WORD_WIDTH-1:0] wordIn,
  input  logic                  wordValid,
  output logic                  wordReady,
  output logic [BYTE_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
`ifdef WORD_SERIALIZER_LAST_EN
  output logic                  dataLast,
`endif
  output logic                  busy
);

  localparam int BEATS = WORD_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((WORD_WIDTH % BYTE_WIDTH) != 0 || BEATS < 1) begin : g_width_check
      $error("word_serializer: WORD_WIDTH must be a positive multiple of BYTE_WIDTH");
    end
  endgenerate

  ser_state_t            state;
  ser_state_t            nextState;
  logic [WORD_WIDTH-1:0] shiftReg;
  logic [CNT_W-1:0]      beatCount;
  logic                  wordAccept;
  logic                  byteTransfer;
  logic                  lastBeat;

  assign lastBeat     = (beatCount == '0);
  assign wordAccept   = wordValid && wordReady;
  assign byteTransfer = dataValid && dataReady;

  // The outgoing beat always sits at the leading end of the shift register.
  assign dataOut = (MSB_FIRST != 0) ? shiftReg[WORD_WIDTH-1 -: BYTE_WIDTH]
                                    : shiftReg[BYTE_WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= IDLE;
      shiftReg  <= '0;
      beatCount <= '0;
    end else begin
      state <= nextState;
      if (wordAccept) begin
        shiftReg  <= wordIn;
        beatCount <= LAST_BEAT;
      end else if (byteTransfer && !lastBeat) begin
        shiftReg  <= (MSB_FIRST != 0) ? (shiftReg << BYTE_WIDTH) : (shiftReg >> BYTE_WIDTH);
        beatCount <= beatCount - 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (wordAccept) nextState = SEND;
      SEND: if (byteTransfer && lastBeat && !wordAccept) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A word can land on the same edge the last beat leaves, giving zero-bubble streaming.
  always_comb begin
    dataValid = (state == SEND);
    busy      = (state == SEND);
    wordReady = !clear && ((state == IDLE) || ((state == SEND) && lastBeat && dataReady));
  end

`ifdef WORD_SERIALIZER_LAST_EN
  assign dataLast = dataValid && lastBeat;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) share stimulus,
// each compared every cycle against a byte-queue model plus literal stream checks.
module tb_word_serializer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] wordIn = 32'h12345678;
  logic        wordValid = 1'b1;
  logic        dataReady = 1'b1;

  logic       wordReadyW [2];
  logic [7:0] dataOutW   [2];
  logic       dataValidW [2];
  logic       busyW      [2];
  logic       lastW      [2];

  always #5 clock = ~clock;

  word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(1)) dutMsb (
    .clock(clock), .clear(clear), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(wordReadyW[0]), .dataOut(dataOutW[0]), .dataValid(dataValidW[0]),
    .dataReady(dataReady),
`ifdef WORD_SERIALIZER_LAST_EN
    .dataLast(lastW[0]),
`endif
    .busy(busyW[0])
  );

  word_serializer #(.WORD_WIDTH(32), .BYTE_WIDTH(8), .MSB_FIRST(0)) dutLsb (
    .clock(clock), .clear(clear), .wordIn(wordIn), .wordValid(wordValid),
    .wordReady(wordReadyW[1]), .dataOut(dataOutW[1]), .dataValid(dataValidW[1]),
    .dataReady(dataReady),
`ifdef WORD_SERIALIZER_LAST_EN
    .dataLast(lastW[1]),
`endif
    .busy(busyW[1])
  );

`ifndef WORD_SERIALIZER_LAST_EN
  assign lastW[0] = 1'b0;
  assign lastW[1] = 1'b0;
`endif

  int passCount = 0;
  int checkCount = 0;
  int cycleNo = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleNo);
  endtask

  // Model: each word becomes a queue of pending bytes in transmit order.
  typedef struct {logic [7:0] b; bit last;} beat_t;
  beat_t      pending [2][$];
  logic [7:0] heldByte [2] = '{8'h00, 8'h00};

  function automatic bit expReady(input int w);
    return !clear && (pending[w].size() == 0 || (pending[w].size() == 1 && dataReady));
  endfunction

  always @(posedge clock) begin
    cycleNo++;
    for (int w = 0; w < 2; w++) begin
      if (clear) begin
        pending[w].delete();
        heldByte[w] = 8'h00;
      end else begin
        bit acc;
        acc = wordValid && expReady(w);
        if (pending[w].size() != 0 && dataReady) begin
          heldByte[w] = pending[w][0].b;
          void'(pending[w].pop_front());
        end
        if (acc)
          for (int k = 0; k < 4; k++) begin
            beat_t nb;
            nb.b    = (w == 0) ? wordIn[31 - 8*k -: 8] : wordIn[8*k +: 8];
            nb.last = (k == 3);
            pending[w].push_back(nb);
          end
      end
    end
  end

  // Every-cycle comparison, sampled mid-cycle after inputs have settled.
  typedef struct {logic [7:0] b; int cyc; logic last;} log_t;
  log_t txLog [2][$];

  always @(negedge clock) begin
    for (int w = 0; w < 2; w++) begin
      bit ev;
      ev = pending[w].size() != 0;
      check($sformatf("wordReady[%0d]", w), wordReadyW[w], expReady(w));
      check($sformatf("dataValid[%0d]", w), dataValidW[w], ev);
      check($sformatf("busy[%0d]", w), busyW[w], ev);
      check($sformatf("dataOut[%0d]", w), dataOutW[w], ev ? pending[w][0].b : heldByte[w]);
`ifdef WORD_SERIALIZER_LAST_EN
      check($sformatf("dataLast[%0d]", w), lastW[w], ev && pending[w][0].last);
`endif
      if (!clear && dataValidW[w] && dataReady) begin
        log_t e;
        e.b = dataOutW[w]; e.cyc = cycleNo; e.last = lastW[w];
        txLog[w].push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    bit done = 0;
    wordIn = w;
    wordValid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (wordReadyW[0]) done = 1;
      @(posedge clock);
      #1;
    end
    check("accept_within_bound", done, 1'b1);
  endtask

  // Literal check of the transferred byte stream: values, count, spacing, start cycle.
  task automatic checkLog(input string name, input int w, input logic [63:0] expVec,
                          input int n, input int span, input int firstCyc);
    check({name, ".count"}, txLog[w].size(), n);
    if (txLog[w].size() == n) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s.byte%0d", name, i), txLog[w][i].b, expVec[63 - 8*i -: 8]);
`ifdef WORD_SERIALIZER_LAST_EN
        check($sformatf("%s.last%0d", name, i), txLog[w][i].last, ((i % 4) == 3));
`endif
      end
      check({name, ".span"}, txLog[w][n-1].cyc - txLog[w][0].cyc, span);
      check({name, ".first"}, txLog[w][0].cyc, firstCyc);
    end
  endtask

  task automatic clearLogs();
    txLog[0].delete();
    txLog[1].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int first;

    // Reset held 5 clocks with wordValid high.
    repeat (5) tick();
    clear = 1'b0;
    wordValid = 1'b0;
    @(negedge clock);
    check("ready_after_clear_msb", wordReadyW[0], 1'b1);
    check("ready_after_clear_lsb", wordReadyW[1], 1'b1);
    check("dataOut_after_clear", dataOutW[0], 8'h00);
    tick();

    // Single word; wordIn scrambled after accept must not matter.
    clearLogs();
    sendWord(32'h44771100);
    first = cycleNo;
    wordValid = 1'b0;
    wordIn = 32'hFFFFFFFF;
    repeat (6) tick();
    checkLog("basic_msb", 0, 64'h44771100_00000000, 4, 3, first);
    checkLog("basic_lsb", 1, 64'h00117744_00000000, 4, 3, first);

    // Back-to-back words with zero bubble.
    clearLogs();
    sendWord(32'hDEADBEEF);
    first = cycleNo;
    sendWord(32'h01020304);
    wordValid = 1'b0;
    repeat (8) tick();
    checkLog("b2b_msb", 0, 64'hDEADBEEF_01020304, 8, 7, first);
    checkLog("b2b_lsb", 1, 64'hEFBEADDE_04030201, 8, 7, first);

    // Backpressure for 3 cycles while 77 is presented.
    clearLogs();
    sendWord(32'h44771100);
    first = cycleNo;
    wordValid = 1'b0;
    tick();
    dataReady = 1'b0;
    repeat (3) tick();
    dataReady = 1'b1;
    repeat (5) tick();
    checkLog("stall_msb", 0, 64'h44771100_00000000, 4, 6, first);

    // Clear pulse right after 77 transfers; remaining bytes discarded.
    clearLogs();
    sendWord(32'h44771100);
    first = cycleNo;
    wordValid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clock);
    check("valid_after_pulse", dataValidW[0], 1'b0);
    check("busy_after_pulse", busyW[0], 1'b0);
    checkLog("pre_clear_msb", 0, 64'h44770000_00000000, 2, 1, first);
    @(posedge clock);
    #1;
    clearLogs();
    sendWord(32'hA1B2C3D4);
    first = cycleNo;
    wordValid = 1'b0;
    repeat (6) tick();
    checkLog("post_clear_msb", 0, 64'hA1B2C3D4_00000000, 4, 3, first);
    checkLog("post_clear_lsb", 1, 64'hD4C3B2A1_00000000, 4, 3, first);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
